ascon_intr_ctrl: RTL and testbench
==================================

ASCON_INTR_CTRL -- requirements
Module: ascon_intr_ctrl

Interface
REQ-001 The block SHALL have parameter C_NUM_OF_INTR, default 2, giving the number of interrupt sources (1..32).
REQ-002 The block SHALL have parameter C_IRQ_ACTIVE_HIGH, default 1: 1 drives irq high when active, 0 drives it low.
REQ-003 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5; the data width is fixed at 32.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: ACLK in 1, rising-edge clock; ARESET in 1, synchronous, active-high.
REQ-005 The block SHALL have write-address ports: S_AXI_AWADDR in C_S_AXI_ADDR_WIDTH; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
REQ-006 The block SHALL have write-data ports: S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
REQ-007 The block SHALL have write-response ports: S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
REQ-008 The block SHALL have read-address ports: S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
REQ-009 The block SHALL have read-data ports: S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-010 The block SHALL have src_evt in C_NUM_OF_INTR, the event lines from the ASCON core: bit0 = operation done, bit1 = tag mismatch.
REQ-011 The block SHALL have irq out 1, the level interrupt to the processor.

Function
REQ-012 The register map SHALL be: 0x00 GIE (bit0); 0x04 IER (bits C_NUM_OF_INTR-1:0); 0x08 ISR (raw status, RO); 0x0C IAR (write-1-to-clear, reads 0); 0x10 IPR (pending, RO).
REQ-013 A write SHALL be accepted only when AWVALID and WVALID are both high and BVALID is low; AWREADY and WREADY SHALL pulse high together for exactly one cycle.
REQ-014 BVALID SHALL assert in the cycle after acceptance and hold, with BRESP=OKAY, until a cycle in which BREADY is high.
REQ-015 A read SHALL be accepted when ARVALID is high and RVALID is low; ARREADY SHALL pulse for one cycle.
REQ-016 RVALID SHALL assert in the next cycle with RDATA latched and RRESP=OKAY, and RDATA SHALL stay stable until RREADY is high.
REQ-017 Read and write channels SHALL operate independently; a simultaneous read and write of the same register SHALL return the pre-write value.
REQ-018 A write SHALL update only bytes whose WSTRB bit is set; register bits at or above C_NUM_OF_INTR SHALL read 0.
REQ-019 An access to an unmapped offset SHALL complete with OKAY, and a read of it SHALL return 0 and a write SHALL be ignored.
REQ-020 Each src_evt bit SHALL be rising-edge detected against a registered copy; an edge sampled at edge k SHALL set the ISR bit visible from cycle k+1.
REQ-021 A held-high src_evt SHALL set ISR only once.
REQ-022 A 1 written to an IAR bit SHALL clear the matching ISR bit; if a new edge occurs in the same cycle, the set SHALL win and the bit SHALL stay 1.
REQ-023 IPR SHALL equal ISR & IER combinationally.
REQ-024 irq SHALL be registered: active from cycle k+2 after the triggering edge iff GIE[0] and |IPR, otherwise inactive; polarity SHALL be set by C_IRQ_ACTIVE_HIGH.
REQ-025 Clearing GIE or IER SHALL deassert irq within one cycle without clearing ISR.

Reset
REQ-026 While ARESET is high at a clock edge, GIE, IER and ISR SHALL be 0, the edge-detect registers SHALL be 0, and all READY/VALID outputs SHALL be 0.
REQ-027 While ARESET is high, RDATA SHALL be 0, BRESP and RRESP SHALL be 00, and irq SHALL be inactive (0 if C_IRQ_ACTIVE_HIGH=1, else 1).
REQ-028 A reset asserted mid-transaction SHALL abandon that transaction, with no response issued after reset.
REQ-029 After reset deasserts, the first accepted transaction SHALL complete normally.

Verification
REQ-030 Bench SHALL cover: after reset, read 0x00/0x04/0x08/0x10 -> all 0x00000000, irq=0, OKAY.
REQ-031 Bench SHALL cover: write GIE=1, IER=1, pulse src_evt[0] for one cycle -> ISR=0x1, IPR=0x1, irq=1 exactly 2 cycles after the pulse.
REQ-032 Bench SHALL cover: then write IAR=0x1 -> ISR=0x0, irq=0 the cycle after the write is accepted; read IPR -> 0x0.
REQ-033 Bench SHALL cover: IER=0x1, src_evt[1] edge -> ISR=0x2, IPR=0x0, irq stays 0; then IER=0x3 -> irq=1.
REQ-034 Bench SHALL cover: IAR=0x1 written in the same cycle as a src_evt[0] edge -> ISR bit0 remains 1 and irq stays 1.
REQ-035 Bench SHALL cover: AWVALID high with WVALID delayed 3 cycles and BREADY held low 4 cycles -> no AWREADY until WVALID, BVALID held, no second write accepted; ARESET during BVALID -> BVALID=0 next cycle.

Source files
------------

// File: rtl/ascon_intr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ascon_intr_ctrl_if
// Brief    : AXI4-Lite register-port bundle for the ASCON interrupt controller
// Revision : 1.0 - initial release
// ============================================================================
interface ascon_intr_ctrl_if #(
    parameter int C_S_AXI_ADDR_WIDTH = 5
);
    logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR;
    logic                          S_AXI_AWVALID;
    logic                          S_AXI_AWREADY;
    logic [31:0]                   S_AXI_WDATA;
    logic [3:0]                    S_AXI_WSTRB;
    logic                          S_AXI_WVALID;
    logic                          S_AXI_WREADY;
    logic [1:0]                    S_AXI_BRESP;
    logic                          S_AXI_BVALID;
    logic                          S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR;
    logic                          S_AXI_ARVALID;
    logic                          S_AXI_ARREADY;
    logic [31:0]                   S_AXI_RDATA;
    logic [1:0]                    S_AXI_RRESP;
    logic                          S_AXI_RVALID;
    logic                          S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface
`default_nettype wire

// File: rtl/ascon_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ascon_intr_ctrl
// Brief    : AXI4-Lite interrupt controller latching ASCON core event edges
// Revision : 1.0 - initial release
// ============================================================================
module ascon_intr_ctrl #(
    parameter int C_NUM_OF_INTR      = 2,
    parameter int C_IRQ_ACTIVE_HIGH  = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  wire logic                     ACLK,
    input  wire logic                     ARESET,
    ascon_intr_ctrl_if.slave              s_axi,
    input  wire logic [C_NUM_OF_INTR-1:0] src_evt,
    output logic                          irq
);
    localparam int                C_IDX_W   = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [C_IDX_W-1:0] C_IDX_GIE = C_IDX_W'(0);
    localparam logic [C_IDX_W-1:0] C_IDX_IER = C_IDX_W'(1);
    localparam logic [C_IDX_W-1:0] C_IDX_ISR = C_IDX_W'(2);
    localparam logic [C_IDX_W-1:0] C_IDX_IAR = C_IDX_W'(3);
    localparam logic [C_IDX_W-1:0] C_IDX_IPR = C_IDX_W'(4);
    localparam logic               C_IRQ_ON  = (C_IRQ_ACTIVE_HIGH != 0);
    localparam logic               C_IRQ_OFF = ~C_IRQ_ON;

    logic                     r_gie_q, w_gie_d;
    logic [C_NUM_OF_INTR-1:0] r_ier_q, w_ier_d;
    logic [C_NUM_OF_INTR-1:0] r_isr_q, w_isr_d;
    logic [C_NUM_OF_INTR-1:0] r_evt_q, w_evt_d;
    logic                     r_awready_q, w_awready_d;
    logic                     r_bvalid_q, w_bvalid_d;
    logic                     r_arready_q, w_arready_d;
    logic                     r_rvalid_q, w_rvalid_d;
    logic [31:0]              r_rdata_q, w_rdata_d;
    logic                     r_irq_q, w_irq_d;

    logic                     w_wr_fire, w_rd_fire;
    logic [C_IDX_W-1:0]       w_wr_idx, w_rd_idx;
    logic [31:0]              w_wmask, w_wdata_m, w_rd_val;
    logic [C_NUM_OF_INTR-1:0] w_rise, w_clr, w_ipr;
    logic                     w_unused;

    assign s_axi.S_AXI_AWREADY = r_awready_q;
    assign s_axi.S_AXI_WREADY  = r_awready_q;
    assign s_axi.S_AXI_BVALID  = r_bvalid_q;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_ARREADY = r_arready_q;
    assign s_axi.S_AXI_RVALID  = r_rvalid_q;
    assign s_axi.S_AXI_RDATA   = r_rdata_q;
    assign s_axi.S_AXI_RRESP   = 2'b00;
    assign irq                 = r_irq_q;

    always_comb begin
        w_wr_fire = r_awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
        w_rd_fire = r_arready_q & s_axi.S_AXI_ARVALID;
        w_wr_idx  = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        w_rd_idx  = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
        w_wmask   = {{8{s_axi.S_AXI_WSTRB[3]}}, {8{s_axi.S_AXI_WSTRB[2]}},
                     {8{s_axi.S_AXI_WSTRB[1]}}, {8{s_axi.S_AXI_WSTRB[0]}}};
        w_wdata_m = s_axi.S_AXI_WDATA & w_wmask;

        w_rise  = src_evt & ~r_evt_q;
        w_evt_d = src_evt;

        w_clr = '0;
        if (w_wr_fire && (w_wr_idx == C_IDX_IAR)) begin
            w_clr = w_wdata_m[C_NUM_OF_INTR-1:0];
        end

        w_gie_d = r_gie_q;
        if (w_wr_fire && (w_wr_idx == C_IDX_GIE) && s_axi.S_AXI_WSTRB[0]) begin
            w_gie_d = s_axi.S_AXI_WDATA[0];
        end

        w_ier_d = r_ier_q;
        if (w_wr_fire && (w_wr_idx == C_IDX_IER)) begin
            w_ier_d = (r_ier_q & ~w_wmask[C_NUM_OF_INTR-1:0]) | w_wdata_m[C_NUM_OF_INTR-1:0];
        end

        // A same-cycle edge beats an acknowledge.
        w_isr_d = (r_isr_q & ~w_clr) | w_rise;
        w_ipr   = r_isr_q & r_ier_q;

        // Enables and acknowledges act on irq at once; fresh edges reach it a cycle after ISR.
        w_irq_d = (w_gie_d && (|(w_ier_d & r_isr_q & ~(w_clr & ~w_rise)))) ? C_IRQ_ON : C_IRQ_OFF;

        w_awready_d = s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~r_bvalid_q & ~r_awready_q;
        w_bvalid_d  = w_wr_fire | (r_bvalid_q & ~s_axi.S_AXI_BREADY);
        w_arready_d = s_axi.S_AXI_ARVALID & ~r_rvalid_q & ~r_arready_q;
        w_rvalid_d  = w_rd_fire | (r_rvalid_q & ~s_axi.S_AXI_RREADY);

        case (w_rd_idx)
            C_IDX_GIE: w_rd_val = {31'b0, r_gie_q};
            C_IDX_IER: w_rd_val = 32'(r_ier_q);
            C_IDX_ISR: w_rd_val = 32'(r_isr_q);
            C_IDX_IPR: w_rd_val = 32'(w_ipr);
            default:   w_rd_val = 32'b0;
        endcase
        w_rdata_d = w_rd_fire ? w_rd_val : r_rdata_q;

        w_unused = ^{w_wdata_m, w_wmask, s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_gie_q     <= 1'b0;
            r_ier_q     <= '0;
            r_isr_q     <= '0;
            r_evt_q     <= '0;
            r_awready_q <= 1'b0;
            r_bvalid_q  <= 1'b0;
            r_arready_q <= 1'b0;
            r_rvalid_q  <= 1'b0;
            r_rdata_q   <= 32'b0;
            r_irq_q     <= C_IRQ_OFF;
        end else begin
            r_gie_q     <= w_gie_d;
            r_ier_q     <= w_ier_d;
            r_isr_q     <= w_isr_d;
            r_evt_q     <= w_evt_d;
            r_awready_q <= w_awready_d;
            r_bvalid_q  <= w_bvalid_d;
            r_arready_q <= w_arready_d;
            r_rvalid_q  <= w_rvalid_d;
            r_rdata_q   <= w_rdata_d;
            r_irq_q     <= w_irq_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ascon_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_intr_ctrl
// Brief    : Directed plus randomized self-checking bench for ascon_intr_ctrl
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascon_intr_ctrl;
    localparam int         N     = 2;
    localparam logic [4:0] A_GIE = 5'h00;
    localparam logic [4:0] A_IER = 5'h04;
    localparam logic [4:0] A_ISR = 5'h08;
    localparam logic [4:0] A_IAR = 5'h0C;
    localparam logic [4:0] A_IPR = 5'h10;
    localparam logic [4:0] A_BAD = 5'h14;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] src_evt;
    logic         irq;
    int           errors = 0;
    int           checks = 0;

    // Reference model: register contents as the software-visible map describes them
    logic         m_gie;
    logic [N-1:0] m_ier, m_isr, m_prev, m_clr;

    ascon_intr_ctrl_if #(.C_S_AXI_ADDR_WIDTH(5)) bus ();

    ascon_intr_ctrl #(
        .C_NUM_OF_INTR      (N),
        .C_IRQ_ACTIVE_HIGH  (1),
        .C_S_AXI_ADDR_WIDTH (5)
    ) dut (
        .ACLK    (clk),
        .ARESET  (rst),
        .s_axi   (bus),
        .src_evt (src_evt),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] smask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic m_irq();
        return m_gie && (|(m_isr & m_ier));
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_isr = '0; m_prev = '0; m_gie = 1'b0; m_ier = '0;
        end else begin
            m_isr  = (m_isr & ~m_clr) | (src_evt & ~m_prev);
            m_prev = src_evt;
        end
        m_clr = '0;
        #1;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input bit use_evt, input logic [N-1:0] evt, output logic irq_after);
        int n;
        logic [31:0] msk;
        msk = smask(strb);
        bus.S_AXI_AWADDR = addr; bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        n = 0;
        tick();
        while (bus.S_AXI_AWREADY !== 1'b1 && n < 20) begin tick(); n++; end
        check("wr_awready", {31'b0, bus.S_AXI_AWREADY}, 32'd1);
        if (use_evt) src_evt = evt;
        if (addr == A_IAR) m_clr = data[N-1:0] & msk[N-1:0];
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        irq_after = irq;
        if (addr == A_GIE && strb[0]) m_gie = data[0];
        if (addr == A_IER) m_ier = (m_ier & ~msk[N-1:0]) | (data[N-1:0] & msk[N-1:0]);
        check("wr_bvalid", {31'b0, bus.S_AXI_BVALID}, 32'd1);
        check("wr_bresp", {30'b0, bus.S_AXI_BRESP}, 32'd0);
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        logic dummy;
        axi_write(addr, data, 4'hF, 1'b0, '0, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp, input int hold);
        int n;
        bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
        n = 0;
        tick();
        while (bus.S_AXI_ARREADY !== 1'b1 && n < 20) begin tick(); n++; end
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        check({tag, "_rvalid"}, {31'b0, bus.S_AXI_RVALID}, 32'd1);
        check({tag, "_rresp"}, {30'b0, bus.S_AXI_RRESP}, 32'd0);
        check(tag, bus.S_AXI_RDATA, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold"}, bus.S_AXI_RDATA, exp);
        end
        bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        logic ia;
        rst = 1'b1; src_evt = '0; m_clr = '0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WDATA = '0;
        bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
        repeat (3) tick();
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_ready", {30'b0, bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}, 32'd0);
        check("rst_valid", {30'b0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'd0);
        check("rst_rdata", bus.S_AXI_RDATA, 32'd0);
        rst = 1'b0;
        tick();

        rd_check("rst_gie", A_GIE, 32'd0, 0);
        rd_check("rst_ier", A_IER, 32'd0, 0);
        rd_check("rst_isr", A_ISR, 32'd0, 0);
        rd_check("rst_ipr", A_IPR, 32'd0, 0);

        // Single-cycle event pulse with everything enabled
        wr(A_GIE, 32'd1);
        wr(A_IER, 32'd1);
        src_evt = 2'b01;
        tick();
        src_evt = 2'b00;
        check("irq_pulse_plus1", {31'b0, irq}, 32'd0);
        tick();
        check("irq_pulse_plus2", {31'b0, irq}, 32'd1);
        rd_check("isr_after_pulse", A_ISR, 32'd1, 2);
        rd_check("ipr_after_pulse", A_IPR, 32'd1, 0);

        axi_write(A_IAR, 32'd1, 4'hF, 1'b0, '0, ia);
        check("irq_after_ack", {31'b0, ia}, 32'd0);
        rd_check("isr_after_ack", A_ISR, 32'd0, 0);
        rd_check("ipr_after_ack", A_IPR, 32'd0, 0);

        // Masked source, then enable it
        src_evt = 2'b10;
        repeat (3) tick();
        check("irq_masked", {31'b0, irq}, 32'd0);
        rd_check("isr_masked", A_ISR, 32'd2, 0);
        rd_check("ipr_masked", A_IPR, 32'd0, 0);
        axi_write(A_IER, 32'd3, 4'hF, 1'b0, '0, ia);
        check("irq_on_enable", {31'b0, ia}, 32'd1);
        // Held-high source must not re-set after acknowledge
        wr(A_IAR, 32'd2);
        repeat (2) tick();
        rd_check("isr_held_once", A_ISR, 32'd0, 0);
        check("irq_held_once", {31'b0, irq}, 32'd0);
        src_evt = 2'b00;
        tick();

        // Acknowledge colliding with a fresh edge
        src_evt = 2'b01; tick(); src_evt = 2'b00; tick(); tick();
        check("irq_before_collide", {31'b0, irq}, 32'd1);
        axi_write(A_IAR, 32'd1, 4'hF, 1'b1, 2'b01, ia);
        check("irq_collide_accept", {31'b0, ia}, 32'd1);
        src_evt = 2'b00;
        check("irq_collide_after", {31'b0, irq}, 32'd1);
        rd_check("isr_collide", A_ISR, 32'd1, 0);

        // Concurrent read and write of IER returns the old value
        bus.S_AXI_AWADDR = A_IER; bus.S_AXI_WDATA = 32'd1; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = A_IER; bus.S_AXI_ARVALID = 1'b1;
        tick();
        check("dual_ready", {30'b0, bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}, 32'd3);
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        m_ier = 2'b01;
        check("dual_valids", {30'b0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'd3);
        check("dual_rdata_old", bus.S_AXI_RDATA, 32'd3);
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        rd_check("ier_new", A_IER, 32'd1, 0);

        // Byte strobes, width masking, unmapped offsets, write-only IAR
        axi_write(A_IER, 32'd3, 4'b1110, 1'b0, '0, ia);
        rd_check("ier_strobe_off", A_IER, 32'd1, 0);
        wr(A_IER, 32'hFFFF_FFFF);
        rd_check("ier_width", A_IER, 32'd3, 0);
        wr(A_BAD, 32'hFFFF_FFFF);
        rd_check("unmapped", A_BAD, 32'd0, 0);
        rd_check("iar_reads0", A_IAR, 32'd0, 0);

        // GIE gates irq without touching ISR
        axi_write(A_GIE, 32'd0, 4'hF, 1'b0, '0, ia);
        check("irq_gie_off", {31'b0, ia}, 32'd0);
        rd_check("isr_gie_off", A_ISR, 32'd1, 0);
        axi_write(A_GIE, 32'd1, 4'hF, 1'b0, '0, ia);
        check("irq_gie_on", {31'b0, ia}, 32'd1);

        // Randomized traffic against the reference model
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    src_evt = N'($urandom_range(0, 3));
                    repeat ($urandom_range(1, 3)) tick();
                end
                1: wr(A_IAR, 32'($urandom_range(0, 3)));
                2: axi_write(A_IER, $urandom, 4'($urandom_range(0, 15)), 1'b0, '0, ia);
                default: wr(A_GIE, 32'($urandom_range(0, 1)));
            endcase
            rd_check("rnd_isr", A_ISR, 32'(m_isr), 0);
            rd_check("rnd_ipr", A_IPR, 32'(m_isr & m_ier), 0);
            check("rnd_irq", {31'b0, irq}, {31'b0, m_irq()});
        end
        src_evt = '0;
        tick();

        // Stalled write channel, back-pressured response, reset during BVALID
        bus.S_AXI_AWADDR = A_IER; bus.S_AXI_WDATA = 32'd0; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_no_awready", {31'b0, bus.S_AXI_AWREADY}, 32'd0);
        end
        bus.S_AXI_WVALID = 1'b1;
        tick();
        check("stall_awready", {31'b0, bus.S_AXI_AWREADY}, 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("bp_bvalid", {31'b0, bus.S_AXI_BVALID}, 32'd1);
            tick();
            check("bp_no_second", {31'b0, bus.S_AXI_AWREADY}, 32'd0);
        end
        rst = 1'b1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        tick();
        check("rst_bvalid", {31'b0, bus.S_AXI_BVALID}, 32'd0);
        check("rst_irq2", {31'b0, irq}, 32'd0);
        check("rst_rdata2", bus.S_AXI_RDATA, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_no_resp", {31'b0, bus.S_AXI_BVALID}, 32'd0);
        wr(A_GIE, 32'd1);
        rd_check("post_rst_gie", A_GIE, 32'd1, 0);
        rd_check("post_rst_ier", A_IER, 32'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
